// File: rtl/accumulator_control_unit.sv
// rtl/accumulator_control_unit.sv - fetch/decode/execute sequencer for the 16-bit accumulator machine
module accumulator_control_unit #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [3:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  halted,
  output logic                  illegal_op,
  output logic [DATA_WIDTH-1:0] ac_out,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  typedef enum logic [2:0] {
    S_FETCH, S_FWAIT, S_FLOAD, S_DECODE, S_RWAIT, S_EXEC, S_STORE, S_HALTED
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [ADDR_WIDTH-1:0] r_mar, w_mar_nxt;
  logic [DATA_WIDTH-1:0] r_ac, w_ac_nxt;
  logic [DATA_WIDTH-1:0] r_ir, w_ir_nxt;

  logic [3:0]            w_op;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_mbr;
  logic                  w_skip;

  assign w_op   = r_ir[DATA_WIDTH-1 -: 4];
  assign w_addr = {{(ADDR_WIDTH-12){1'b0}}, r_ir[11:0]};
  // The memory word is consumed the same cycle it arrives, so the buffer is the read bus itself.
  assign w_mbr  = mem_rdata;

  always_comb begin
    w_skip = 1'b0;
    case (r_ir[11:10])
      2'b00:   w_skip = r_ac[DATA_WIDTH-1];
      2'b01:   w_skip = (r_ac == '0);
      2'b10:   w_skip = !r_ac[DATA_WIDTH-1] && (r_ac != '0);
      default: w_skip = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_mar   <= '0;
      r_ac    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_mar   <= w_mar_nxt;
      r_ac    <= w_ac_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  // Strobes decode straight from the state so an async reset clears them without a clock.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_mar_nxt   = r_mar;
    w_ac_nxt    = r_ac;
    w_ir_nxt    = r_ir;
    mem_we      = 1'b0;
    illegal_op  = 1'b0;
    alu_opcode  = 4'b0000;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (run) begin
          w_mar_nxt   = r_pc;
          w_state_nxt = S_FWAIT;
        end
      end
      S_FWAIT: w_state_nxt = S_FLOAD;
      S_FLOAD: begin
        w_ir_nxt    = mem_rdata;
        w_pc_nxt    = r_pc + 1'b1;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_state_nxt = S_FETCH;
        case (w_op)
          OP_LOAD, OP_ADD, OP_SUBT, OP_AND, OP_OR: begin
            w_mar_nxt   = w_addr;
            w_state_nxt = S_RWAIT;
          end
          OP_STORE: begin
            w_mar_nxt   = w_addr;
            w_state_nxt = S_STORE;
          end
          OP_JUMP: w_pc_nxt = w_addr;
          OP_SKIP: if (w_skip) w_pc_nxt = r_pc + 1'b1;
          OP_HALT: w_state_nxt = S_HALTED;
          OP_NOP:  w_state_nxt = S_FETCH;
          default: illegal_op = 1'b1;
        endcase
      end
      S_RWAIT: w_state_nxt = S_EXEC;
      S_EXEC: begin
        case (w_op)
          OP_SUBT: alu_opcode = 4'b0001;
          OP_AND:  alu_opcode = 4'b1000;
          OP_OR:   alu_opcode = 4'b1001;
          default: alu_opcode = 4'b0000;
        endcase
        w_ac_nxt    = (w_op == OP_LOAD) ? w_mbr : alu_result;
        w_state_nxt = S_FETCH;
      end
      S_STORE: begin
        mem_we      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_HALTED: halted = 1'b1;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  assign mem_addr  = r_mar;
  assign mem_wdata = r_ac;
  assign alu_a     = r_ac;
  assign alu_b     = mem_rdata;
  assign ac_out    = r_ac;
  assign pc_out    = r_pc;

endmodule

// File: tb/tb_accumulator_control_unit.sv
// tb/tb_accumulator_control_unit.sv - directed table-driven bench for accumulator_control_unit
module tb_accumulator_control_unit;

  logic        clk = 1'b0;
  logic        reset, run, run2, mem_load;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_result, ac_out, pc_out;
  logic [3:0]  alu_opcode;
  logic        mem_we, halted, illegal_op;
  logic [15:0] x_mem_addr, x_mem_wdata, x_alu_a, x_alu_b, x_ac_out, x_pc_out;
  logic [15:0] x_mem_rdata, x_alu_result;
  logic [3:0]  x_alu_opcode;
  logic        x_mem_we, x_halted, x_illegal_op;

  logic [15:0] mem [0:65535];
  logic [15:0] img [0:65535];
  int          n_chk = 0, n_fail = 0;
  int          ill_cnt = 0, we_cnt = 0;

  always #5 clk = ~clk;

  accumulator_control_unit u_dut (
    .clk(clk), .reset(reset), .run(run), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .alu_opcode(alu_opcode), .alu_a(alu_a),
    .alu_b(alu_b), .alu_result(alu_result), .halted(halted), .illegal_op(illegal_op),
    .ac_out(ac_out), .pc_out(pc_out)
  );

  accumulator_control_unit #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .reset(reset), .run(run2), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata),
    .mem_we(x_mem_we), .mem_rdata(x_mem_rdata), .alu_opcode(x_alu_opcode), .alu_a(x_alu_a),
    .alu_b(x_alu_b), .alu_result(x_alu_result), .halted(x_halted), .illegal_op(x_illegal_op),
    .ac_out(x_ac_out), .pc_out(x_pc_out)
  );

  assign x_mem_rdata  = 16'h0000;
  assign x_alu_result = 16'h0000;

  always_comb begin
    case (alu_opcode)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      default: alu_result = 16'hDEAD;
    endcase
  end

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 65536; i++) mem[i] <= img[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (illegal_op) ill_cnt <= ill_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_image();
    mem_load = 1'b1;
    @(posedge clk);
    #1 mem_load = 1'b0;
  endtask

  task automatic clear_image();
    for (int i = 0; i < 65536; i++) img[i] = 16'h0000;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    int          cyc;
    logic [15:0] ac;
    logic [15:0] pc;
  } vec_t;

  vec_t tv [19];

  initial begin
    int halt_cyc, ill0, we0;
    logic seen;
    reset = 1'b0; run = 1'b0; run2 = 1'b0; mem_load = 1'b0;

    // Test-plan program 1, loaded while held in reset.
    clear_image();
    img[16'h0] = 16'h1010; img[16'h1] = 16'h3011; img[16'h2] = 16'h2012; img[16'h3] = 16'h7000;
    img[16'h10] = 16'h0005; img[16'h11] = 16'h0007;
    load_image();
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_ac", ac_out, 16'h0000);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal_op, 1'b0);
    chk("rst_aluop", alu_opcode, 4'b0000);
    chk("rst_wrap_pc", x_pc_out, 16'hFFFF);

    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("idle_pc", x_pc_out, 16'hFFFF);
      chk("idle_addr_we", {x_mem_addr, 15'd0, x_mem_we}, 32'h0);
    end
    chk("idle_main_pc", pc_out, 16'h0000);

    run = 1'b1; run2 = 1'b1;
    halt_cyc = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("wrap_fetch_addr", x_mem_addr, 16'hFFFF);
      if (c == 4) chk("wrap_pc", x_pc_out, 16'h0000);
      if (halted && halt_cyc < 0) halt_cyc = c;
    end
    chk("prog1_halt_cycle", halt_cyc, 21);
    chk("prog1_m12", mem[16'h12], 16'h000C);
    chk("prog1_ac", ac_out, 16'h000C);
    chk("prog1_pc", pc_out, 16'h0004);
    chk("prog1_halted", halted, 1'b1);

    // Table-driven program: every opcode class, skip conditions, jump and illegal.
    reset = 1'b0; run = 1'b0; run2 = 1'b0;
    tv[0]  = '{16'h00, 16'h1100, 6, 16'h0003, 16'h0001};
    tv[1]  = '{16'h01, 16'h4101, 6, 16'hFFFE, 16'h0002};
    tv[2]  = '{16'h02, 16'h8000, 4, 16'hFFFE, 16'h0004};
    tv[3]  = '{16'h04, 16'h8400, 4, 16'hFFFE, 16'h0005};
    tv[4]  = '{16'h05, 16'h3102, 6, 16'h0000, 16'h0006};
    tv[5]  = '{16'h06, 16'h8400, 4, 16'h0000, 16'h0008};
    tv[6]  = '{16'h08, 16'h8800, 4, 16'h0000, 16'h0009};
    tv[7]  = '{16'h09, 16'h6103, 6, 16'h00F0, 16'h000A};
    tv[8]  = '{16'h0A, 16'h5104, 6, 16'h0030, 16'h000B};
    tv[9]  = '{16'h0B, 16'h8800, 4, 16'h0030, 16'h000D};
    tv[10] = '{16'h0D, 16'h8C00, 4, 16'h0030, 16'h000E};
    tv[11] = '{16'h0E, 16'h2105, 5, 16'h0030, 16'h000F};
    tv[12] = '{16'h0F, 16'hF123, 4, 16'h0030, 16'h0010};
    tv[13] = '{16'h10, 16'h0000, 4, 16'h0030, 16'h0011};
    tv[14] = '{16'h11, 16'h9020, 4, 16'h0030, 16'h0020};
    tv[15] = '{16'h20, 16'h1106, 6, 16'h8000, 16'h0021};
    tv[16] = '{16'h21, 16'h8000, 4, 16'h8000, 16'h0023};
    tv[17] = '{16'h23, 16'h8800, 4, 16'h8000, 16'h0024};
    tv[18] = '{16'h24, 16'h7000, 4, 16'h8000, 16'h0025};
    clear_image();
    img[16'h03] = 16'h7000; img[16'h07] = 16'h7000; img[16'h0C] = 16'h7000; img[16'h22] = 16'h7000;
    for (int i = 0; i < 19; i++) img[tv[i].addr] = tv[i].instr;
    img[16'h100] = 16'h0003; img[16'h101] = 16'h0005; img[16'h102] = 16'h0002;
    img[16'h103] = 16'h00F0; img[16'h104] = 16'h0F30; img[16'h106] = 16'h8000;
    load_image();
    ill0 = ill_cnt; we0 = we_cnt;
    reset = 1'b1; run = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      chk($sformatf("fetch_addr[%0d]", i), mem_addr, tv[i].addr);
      repeat (tv[i].cyc - 1) @(posedge clk);
      #1;
      chk($sformatf("ac[%0d]", i), ac_out, tv[i].ac);
      chk($sformatf("pc[%0d]", i), pc_out, tv[i].pc);
    end
    chk("tbl_halted", halted, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("tbl_halt_hold", {halted, pc_out, ac_out[14:0]}, {1'b1, 16'h0025, 15'h0000});
    chk("tbl_store_m105", mem[16'h105], 16'h0030);
    chk("tbl_illegal_pulses", ill_cnt - ill0, 1);
    chk("tbl_we_cycles", we_cnt - we0, 1);

    // Reset asserted in the middle of a STORE cycle.
    reset = 1'b0; run = 1'b0;
    clear_image();
    img[16'h0] = 16'h1100; img[16'h1] = 16'h2105;
    img[16'h100] = 16'hABCD; img[16'h105] = 16'h1234;
    load_image();
    reset = 1'b1; run = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(posedge clk); #1;
      if (mem_we) seen = 1'b1;
    end
    chk("store_reached", seen, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("abort_we", mem_we, 1'b0);
    chk("abort_pc", pc_out, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_mem", mem[16'h105], 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
